alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered successor to the CPU's combinational 16-bit ALU. Accepts one operation per valid/ready handshake and returns a registered result with a persistent Z/V/N flag register. Supports saturating add/sub, XOR, lane reduction, shifts/rotate, lane-wise saturating add and plain address add. An optional iterative multiplier adds a multi-cycle path. It sits between the decode/operand-read stage and writeback, and its flag outputs feed branch resolution.

## Interface
- WIDTH, 16: datapath width; multiple of LANE, minimum 8.
- LANE, 4: lane width for PADDSB and RED; divides WIDTH.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted on `in_valid && in_ready`.
- opcode  input  4  operation select.
- in1, in2  input  WIDTH  operands.
- out_valid  output  1  result held in `out`.
- out_ready  input  1  consumer takes result on `out_valid && out_ready`.
- out  output  WIDTH  registered result.
- flags  output  3  [2] Z, [1] V, [0] N; persistent register.

## Operation
- Opcodes:
  - 0000 ADD: saturating.
  - 0001 SUB: in1 + ~in2 + 1, saturating.
  - 0010 XOR.
  - 0011 RED: sum of all LANE-wide lanes of in1 and in2, each treated as signed. Accumulate at WIDTH bits, wrapping.
  - 0100 SLL, 0101 SRA, 0110 ROR: shift amount is in2[$clog2(WIDTH)-1:0].
  - 0111 PADDSB: per-lane signed saturating add.
  - 10xx ADDR: in1 + in2, wraps, no saturation.
  - 1111 MUL: see Configuration.
  - All other opcodes: out = 0.
- Saturation and overflow:
  - Positive overflow saturates to 0111…1; negative overflow saturates to 100…0.
  - V is set when both operand signs match and the raw sum's sign differs. For SUB, the effective sign of in2 is inverted.
- Flag update rules, applied on the same edge the result loads into `out`:
  - ADD/SUB: update Z, V, N.
  - XOR, SLL, SRA, ROR: update Z only; V and N hold.
  - All other opcodes: flags hold.
  - Z = (result == 0); N = result[WIDTH-1].
- State machine:
  - IDLE: default state.
  - MUL: entered only with the macro.
  - HOLD: out_valid=1, waiting for the consumer.
- Transitions:
  - IDLE accepts an operation → HOLD (or MUL).
  - HOLD with out_ready and a new in_valid → HOLD with the new result; back-to-back, no bubble.
  - HOLD with out_ready and no in_valid → IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). in_ready is never 1 in MUL.
- Backpressure: while out_valid && !out_ready, `out` and `flags` are stable.

## Timing
- Reset values: out=0, out_valid=0, flags=3'b000, state=IDLE. in_ready=1 after reset.
- Single-cycle opcodes:
  - Accepted at edge N; out_valid=1 and the result visible after edge N.
  - Latency 1 cycle; throughput 1 per cycle when out_ready is held high.
- MUL: result after WIDTH+1 edges from acceptance. Flags hold.
- Reset asserted mid-MUL or in HOLD: immediate return to reset values. The pending result is discarded.
- Operands are sampled only at acceptance. Changes to in1/in2/opcode afterwards have no effect.

## Configuration
- ALU_PIPE_MULT_EN defined:
  - Opcode 1111 performs a signed WIDTH×WIDTH multiply, keeping the low WIDTH bits.
  - Implemented as a radix-2 shift-add FSM, one partial product per cycle, WIDTH cycles.
  - in_ready=0 throughout.
- ALU_PIPE_MULT_EN undefined:
  - 1111 is an unused opcode: out = 0, flags hold.
  - Single-cycle latency; no MUL state exists.

## Test plan
- Reset then ADD, WIDTH=16, in1=16'h7FFF, in2=16'h0001:
  - out=16'h7FFF, flags=3'b010.
  - Next, SUB with in1=in2=16'h1234 → out=0, flags=3'b100.
- XOR 16'hFFFF^16'h0F0F after a saturating negative ADD (V=1, N=1):
  - out=16'hF0F0, Z=0.
  - V and N unchanged from the preceding ADD.
- PADDSB, in1=16'h7777, in2=16'h1111: out=16'h7777, each lane saturated.
- Hold out_ready=0 for 3 cycles after an ADD with a second op offered:
  - in_ready=0; out and flags stable.
  - Raise out_ready → second result appears on the next edge with no bubble.
- With ALU_PIPE_MULT_EN, MUL 16'hFFFD × 16'h0007:
  - out=16'hFFEB exactly 17 edges after acceptance; in_ready=0 meanwhile.
  - Reset at cycle 8 of the multiply → out=0, out_valid=0, flags=0.
- Without ALU_PIPE_MULT_EN, opcode 1111 → out=0 after 1 cycle, flags unchanged.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between operand-read, alu_pipe and writeback.
// The master drives operations and consumes results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [2:0]       flags;

    modport master (
        output in_valid, opcode, in1, in2, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, opcode, in1, in2, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and persistent Z/V/N flags.
// Define ALU_PIPE_MULT_EN to add the iterative signed multiplier on opcode 1111.
//
// state  | meaning
// S_IDLE | no result held, ready for an operation
// S_HOLD | result valid in out, waiting for the consumer
// S_MUL  | shift-add multiply in progress, input stalled
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int SHW   = $clog2(WIDTH);
    localparam int NLANE = WIDTH / LANE;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = ~SMAX;
    localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
    localparam logic [LANE-1:0]  LMIN = ~LMAX;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

`ifdef ALU_PIPE_MULT_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;
`endif

    state_t state, state_nxt;

    logic             in_ready;
    logic             accept;
    logic             load_res;
    logic [WIDTH-1:0] out_q;
    logic [2:0]       flags_q;
    logic [2:0]       flags_nxt;

    logic [WIDTH-1:0] a, b, b_inv;
    logic [WIDTH-1:0] add_raw, add_sat, sub_raw, sub_sat;
    logic             add_v, sub_v;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sll_res, sra_res, ror_res;
    logic [WIDTH-1:0] red_res, padd_res;
    logic [WIDTH-1:0] alu_res;

    assign a     = bus.in1;
    assign b     = bus.in2;
    assign b_inv = ~b;
    assign sh    = b[SHW-1:0];

    // Overflow: operand signs agree but the raw sum's sign does not.
    assign add_raw = a + b;
    assign add_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_raw[WIDTH-1] != a[WIDTH-1]);
    assign add_sat = add_v ? (a[WIDTH-1] ? SMIN : SMAX) : add_raw;

    assign sub_raw = a + b_inv + WIDTH'(1);
    assign sub_v   = (a[WIDTH-1] == b_inv[WIDTH-1]) && (sub_raw[WIDTH-1] != a[WIDTH-1]);
    assign sub_sat = sub_v ? (a[WIDTH-1] ? SMIN : SMAX) : sub_raw;

    assign sll_res = a << sh;
    assign sra_res = $signed(a) >>> sh;
    assign ror_res = (a >> sh) | (a << (WIDTH - int'(sh)));

    always_comb begin
        red_res = '0;
        for (int i = 0; i < NLANE; i++) begin
            red_res = red_res + WIDTH'($signed(a[i*LANE +: LANE]))
                              + WIDTH'($signed(b[i*LANE +: LANE]));
        end
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        logic [LANE-1:0] la, lb, ls;
        logic            lv;
        assign la = a[g*LANE +: LANE];
        assign lb = b[g*LANE +: LANE];
        assign ls = la + lb;
        assign lv = (la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]);
        assign padd_res[g*LANE +: LANE] = lv ? (la[LANE-1] ? LMIN : LMAX) : ls;
    end

    always_comb begin
        alu_res = '0;
        casez (bus.opcode)
            OP_ADD:    alu_res = add_sat;
            OP_SUB:    alu_res = sub_sat;
            OP_XOR:    alu_res = a ^ b;
            OP_RED:    alu_res = red_res;
            OP_SLL:    alu_res = sll_res;
            OP_SRA:    alu_res = sra_res;
            OP_ROR:    alu_res = ror_res;
            OP_PADDSB: alu_res = padd_res;
            4'b10??:   alu_res = a + b;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        flags_nxt = flags_q;
        case (bus.opcode)
            OP_ADD: flags_nxt = {alu_res == '0, add_v, alu_res[WIDTH-1]};
            OP_SUB: flags_nxt = {alu_res == '0, sub_v, alu_res[WIDTH-1]};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_nxt[2] = (alu_res == '0);
            default: ;
        endcase
    end

`ifdef ALU_PIPE_MULT_EN
    localparam int CNTW = $clog2(WIDTH + 1);

    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier;
    logic [CNTW-1:0]  mul_cnt;

    assign is_mul   = (bus.opcode == 4'b1111);
    assign mul_done = (state == S_MUL) && (mul_cnt == '0);
`endif

    // HOLD only accepts when the consumer is taking the current result.
    assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
`ifdef ALU_PIPE_MULT_EN
        mul_start = 1'b0;
`endif
        if (accept) begin
`ifdef ALU_PIPE_MULT_EN
            if (is_mul) begin
                mul_start = 1'b1;
                state_nxt = S_MUL;
            end else
`endif
            begin
                load_res  = 1'b1;
                state_nxt = S_HOLD;
            end
        end else begin
            case (state)
                S_HOLD: if (bus.out_ready) state_nxt = S_IDLE;
`ifdef ALU_PIPE_MULT_EN
                S_MUL:  if (mul_cnt == '0) state_nxt = S_HOLD;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            flags_q <= '0;
        end else if (load_res) begin
            out_q   <= alu_res;
            flags_q <= flags_nxt;
        end
`ifdef ALU_PIPE_MULT_EN
        else if (mul_done) begin
            out_q <= mul_acc;
        end
`endif
    end

`ifdef ALU_PIPE_MULT_EN
    // Low WIDTH bits of a signed product equal those of the unsigned product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else if (mul_start) begin
            mul_acc    <= '0;
            mul_mcand  <= a;
            mul_mplier <= b;
            mul_cnt    <= CNTW'(WIDTH);
        end else if ((state == S_MUL) && (mul_cnt != '0)) begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt - CNTW'(1);
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == S_HOLD);
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: randomized operations against an arithmetic
// reference model, plus directed vectors for saturation, flags, stalls and reset.
module tb_alu_pipe;
    localparam int W = 16;
    localparam int L = 4;

    localparam longint SMAXI = (longint'(1) << (W - 1)) - 1;
    localparam longint SMINI = -(longint'(1) << (W - 1));
    localparam longint LMAXI = (longint'(1) << (L - 1)) - 1;
    localparam longint LMINI = -(longint'(1) << (L - 1));
    localparam longint LMASK = (longint'(1) << L) - 1;
    localparam logic [W-1:0] SMAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMINV = ~SMAXV;

    typedef struct {
        logic [W-1:0] out;
        logic [2:0]   flags;
        int           rdy;
        bit           mul;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [W-1:0] out;
    logic [2:0] flags;

    alu_pipe_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.opcode    = opcode;
    assign bus.in1       = in1;
    assign bus.in2       = in2;
    assign bus.out_ready = out_ready;
    assign in_ready      = bus.in_ready;
    assign out_valid     = bus.out_valid;
    assign out           = bus.out;
    assign flags         = bus.flags;

    alu_pipe #(.WIDTH(W), .LANE(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    exp_t exp_q[$];
    logic [2:0] mflags = '0;
    bit bp_en = 0;

    function automatic void check(input string name, input longint got, input longint want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    endfunction

    function automatic longint sx(input longint v, input int n);
        return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
    endfunction

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference: signed integer arithmetic, results truncated to W bits.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [2:0] fl);
        exp_t e;
        longint sa = sx(longint'(a), W);
        longint sb = sx(longint'(b), W);
        longint r = 0;
        longint la, lb;
        int sh = int'(b) % W;
        bit v = 0;
        e.flags = fl;
        e.rdy = 0;
        e.mul = 0;
        case (op)
            4'd0, 4'd1: begin
                r = (op == 4'd0) ? sa + sb : sa - sb;
                v = (r > SMAXI) || (r < SMINI);
                r = clampl(r, SMINI, SMAXI);
            end
            4'd2: r = longint'(a ^ b);
            4'd3: for (int i = 0; i < W / L; i++)
                      r += sx((longint'(a) >> (i * L)) & LMASK, L)
                         + sx((longint'(b) >> (i * L)) & LMASK, L);
            4'd4: r = longint'(a) << sh;
            4'd5: r = sa >>> sh;
            4'd6: r = (longint'(a) >> sh) | (longint'(a) << (W - sh));
            4'd7: for (int i = 0; i < W / L; i++) begin
                      la = sx((longint'(a) >> (i * L)) & LMASK, L);
                      lb = sx((longint'(b) >> (i * L)) & LMASK, L);
                      r |= (clampl(la + lb, LMINI, LMAXI) & LMASK) << (i * L);
                  end
            4'd8, 4'd9, 4'd10, 4'd11: r = longint'(a) + longint'(b);
`ifdef ALU_PIPE_MULT_EN
            4'd15: begin
                r = sa * sb;
                e.mul = 1;
            end
`endif
            default: r = 0;
        endcase
        e.out = r[W-1:0];
        if (op == 4'd0 || op == 4'd1)
            e.flags = {e.out == '0, v, e.out[W-1]};
        else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6)
            e.flags[2] = (e.out == '0);
        return e;
    endfunction

    function automatic void push(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int acyc);
        exp_t e = model(op, a, b, mflags);
        e.rdy = e.mul ? acyc + W + 2 : acyc + 1;
        mflags = e.flags;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 0;
        int acyc = 0;
        in_valid = 1'b1;
        opcode = op;
        in1 = a;
        in2 = b;
        for (int g = 0; g < 100 && !acc; g++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                acyc = cyc;
            end
            @(posedge clk);
            if (acc) push(op, a, b, acyc);
            #1;
            if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        opcode = 4'($urandom);
        in1 = W'($urandom);
        in2 = W'($urandom);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_out(input string name, input logic [W-1:0] eo, input logic [2:0] ef);
        bit seen = 0;
        for (int g = 0; g < 40 && !seen; g++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_out"}, out, eo);
        check({name, "_flags"}, flags, ef);
        tick();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        mflags = '0;
        @(negedge clk);
        check({name, "_out"}, out, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_flags"}, flags, 0);
        check({name, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return SMAXV;
            1: return SMINV;
            2: return '0;
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every completed output handshake.
    initial begin
        bit seen = 0;
        int seen_cyc = 0;
        bit stalled = 0;
        logic [W-1:0] held_out;
        logic [2:0] held_flags;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                stalled = 0;
            end else begin
                check("in_ready", in_ready,
                      out_valid ? out_ready : !(exp_q.size() > 0 && exp_q[0].mul));
                if (out_valid && !seen) begin
                    seen = 1;
                    seen_cyc = cyc;
                end
                if (out_valid && !out_ready) begin
                    if (stalled) begin
                        check("stall_out", out, held_out);
                        check("stall_flags", flags, held_flags);
                    end
                    stalled = 1;
                    held_out = out;
                    held_flags = flags;
                end else begin
                    stalled = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_out", out, e.out);
                        check("sb_flags", flags, e.flags);
                        check("sb_latency", seen_cyc, e.rdy);
                    end
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset("reset");

        issue(4'b0000, 16'h7FFF, 16'h0001);
        wait_out("add_sat_pos", 16'h7FFF, 3'b010);
        issue(4'b0001, 16'h1234, 16'h1234);
        wait_out("sub_zero", 16'h0000, 3'b100);
        issue(4'b0000, 16'h8000, 16'hFFFF);
        wait_out("add_sat_neg", 16'h8000, 3'b011);
        issue(4'b0010, 16'hFFFF, 16'h0F0F);
        wait_out("xor_hold_vn", 16'hF0F0, 3'b011);
        issue(4'b0111, 16'h7777, 16'h1111);
        wait_out("paddsb_sat", 16'h7777, 3'b011);
`ifdef ALU_PIPE_MULT_EN
        issue(4'b1111, 16'hFFFD, 16'h0007);
        wait_out("mul", 16'hFFEB, 3'b011);
`else
        issue(4'b1111, 16'hFFFD, 16'h0007);
        wait_out("op1111_zero", 16'h0000, 3'b011);
`endif

        out_ready = 1'b0;
        issue(4'b0000, 16'h0100, 16'h0023);
        in_valid = 1'b1;
        opcode = 4'b0010;
        in1 = 16'h00FF;
        in2 = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out", out, 16'h0123);
            check("bp_flags", flags, 3'b000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(4'b0010, 16'h00FF, 16'h00FF);
        wait_out("bp_second", 16'h0000, 3'b100);

        out_ready = 1'b0;
        issue(4'b1000, 16'h0005, 16'h0006);
        tick();
        do_reset("reset_hold");
        out_ready = 1'b1;
`ifdef ALU_PIPE_MULT_EN
        issue(4'b1111, 16'hFFFD, 16'h0007);
        repeat (7) tick();
        do_reset("reset_mul");
`endif

        bp_en = 1;
        for (int n = 0; n < 400; n++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick());
            repeat ($urandom_range(0, 2)) tick();
        end
        bp_en = 0;
        out_ready = 1'b1;
        for (int g = 0; g < 200 && exp_q.size() > 0; g++) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
